// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        MEM_ADDR,
        MEM_LD,
        MEM_ST,
        WB_ALU,
        WB_LD,
        BRANCH,
        TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_control_retire_counter.sv
// Retired-instruction counter, wraps modulo 2^CNT_W.
// Latency: count reflects an enable on the following clock edge.
// Backpressure: none; counts every cycle en is high, reset has priority.
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear on reset, otherwise bump when enabled.
    always_comb begin
        count_d = count_q;
        if (reset) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V sequencer driving shared memory port and ALU.
// Latency: R/I/store 4 cycles, load 5, branch 3 with zero-wait memory.
// Backpressure: FETCH, MEM_LD and MEM_ST hold strobes until mem_ready.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter bit BNE_MODE = 1'b1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSource,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       AluOp,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_retired
);

    state_t state_q;
    state_t state_d;
    logic   illegal_q;
    logic   illegal_d;
    logic   retire;

    // State and sticky illegal-opcode flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and control decode; everything defaults to idle.
    always_comb begin
        state_d   = state_q;
        retire    = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IorD      = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCSource  = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        AluOp     = ALU_ADD;
        RegWrite  = 1'b0;
        MemToReg  = 1'b0;
        case (state_q)
            FETCH: begin
                // ALU computes PC+4 while the instruction is read.
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                // Speculatively form the branch target in ALUOut.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (opcode)
                    OP_R:                state_d = EXEC_R;
                    OP_I:                state_d = EXEC_I;
                    OP_LOAD, OP_STORE:   state_d = MEM_ADDR;
                    OP_BRANCH:           state_d = BRANCH;
                    default:             state_d = TRAP;
                endcase
            end
            EXEC_R: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                AluOp   = ALU_FUNCT;
                state_d = WB_ALU;
            end
            EXEC_I: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                AluOp   = ALU_FUNCT;
                state_d = WB_ALU;
            end
            MEM_ADDR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                AluOp   = ALU_ADD;
                state_d = (opcode == OP_STORE) ? MEM_ST : MEM_LD;
            end
            MEM_LD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) begin
                    state_d = WB_LD;
                end
            end
            MEM_ST: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            WB_ALU: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            WB_LD: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                // Compare rs1/rs2; PC loads the target held in ALUOut.
                ALUSrcA  = SRCA_RS1;
                ALUSrcB  = SRCB_RS2;
                AluOp    = ALU_SUB;
                PCSource = 1'b1;
                PCWrite  = zero ^ BNE_MODE;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
        illegal_d = illegal_q | (state_d == TRAP);
    end

    assign illegal = illegal_q;

    retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire_counter (
        .clk   (clk),
        .reset (reset),
        .en    (retire),
        .count (instr_retired)
    );

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam int S_FETCH = 0, S_DECODE = 1, S_EXEC_R = 2, S_EXEC_I = 3, S_MEM_ADDR = 4,
                   S_MEM_LD = 5, S_MEM_ST = 6, S_WB_ALU = 7, S_WB_LD = 8, S_BRANCH = 9,
                   S_TRAP = 10;

    localparam logic [6:0] T_R = 7'b0110011, T_I = 7'b0010011, T_LD = 7'b0000011,
                           T_ST = 7'b0100011, T_BR = 7'b1100011, T_BAD = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource, RegWrite, MemToReg, illegal;
    logic [1:0]  ALUSrcA, ALUSrcB, AluOp;
    logic [31:0] instr_retired;

    logic        b_mr, b_mw, b_iord, b_irw, b_pcw, b_pcs, b_rw, b_m2r, b_ill;
    logic [1:0]  b_sa, b_sb, b_op;
    logic [3:0]  b_cnt;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] exp_cnt = 32'd0;

    typedef struct {
        int         st;
        bit         rdy;
        bit         z;
        logic [6:0] op;
    } stim_t;

    stim_t       q_stim[$];
    logic [14:0] q_exp[$];

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .AluOp(AluOp), .RegWrite(RegWrite), .MemToReg(MemToReg), .illegal(illegal),
        .instr_retired(instr_retired)
    );

    // Second instance: narrow counter, beq polarity.
    multicycle_control #(.BNE_MODE(1'b0), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .MemRead(b_mr), .MemWrite(b_mw), .IorD(b_iord), .IRWrite(b_irw),
        .PCWrite(b_pcw), .PCSource(b_pcs), .ALUSrcA(b_sa), .ALUSrcB(b_sb),
        .AluOp(b_op), .RegWrite(b_rw), .MemToReg(b_m2r), .illegal(b_ill),
        .instr_retired(b_cnt)
    );

    wire [14:0] act_vec = {MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource,
                           ALUSrcA, ALUSrcB, AluOp, RegWrite, MemToReg, illegal};

    // Reference control word for a state under given inputs (bne polarity).
    function automatic logic [14:0] exp_of(int st, bit rdy, bit z);
        logic mr, mw, iord, irw, pcw, pcs, rw, m2r, ill;
        logic [1:0] sa, sb, op;
        {mr, mw, iord, irw, pcw, pcs, rw, m2r, ill} = 9'b0;
        sa = 2'b00; sb = 2'b00; op = 2'b00;
        case (st)
            S_FETCH:    begin mr = 1'b1; sb = 2'b01; irw = rdy; pcw = rdy; end
            S_DECODE:   begin sa = 2'b10; sb = 2'b10; end
            S_EXEC_R:   begin sa = 2'b01; op = 2'b10; end
            S_EXEC_I:   begin sa = 2'b01; sb = 2'b10; op = 2'b10; end
            S_MEM_ADDR: begin sa = 2'b01; sb = 2'b10; end
            S_MEM_LD:   begin mr = 1'b1; iord = 1'b1; end
            S_MEM_ST:   begin mw = 1'b1; iord = 1'b1; end
            S_WB_ALU:   begin rw = 1'b1; end
            S_WB_LD:    begin rw = 1'b1; m2r = 1'b1; end
            S_BRANCH:   begin sa = 2'b01; op = 2'b01; pcs = 1'b1; pcw = ~z; end
            S_TRAP:     begin ill = 1'b1; end
            default:    begin end
        endcase
        return {mr, mw, iord, irw, pcw, pcs, sa, sb, op, rw, m2r, ill};
    endfunction

    task automatic push(int st, bit rdy, bit z, logic [6:0] op);
        stim_t s;
        s.st = st; s.rdy = rdy; s.z = z; s.op = op;
        q_stim.push_back(s);
        q_exp.push_back(exp_of(st, rdy, z));
    endtask

    // Queue one whole instruction; stalls are cycles with mem_ready low.
    task automatic queue_instr(logic [6:0] op, int fs, int ms, bit z);
        for (int k = 0; k < fs; k++) push(S_FETCH, 1'b0, z, op);
        push(S_FETCH, 1'b1, z, op);
        push(S_DECODE, 1'($urandom_range(0, 1)), z, op);
        case (op)
            T_R: begin
                push(S_EXEC_R, 1'($urandom_range(0, 1)), z, op);
                push(S_WB_ALU, 1'($urandom_range(0, 1)), z, op);
            end
            T_I: begin
                push(S_EXEC_I, 1'($urandom_range(0, 1)), z, op);
                push(S_WB_ALU, 1'($urandom_range(0, 1)), z, op);
            end
            T_LD: begin
                push(S_MEM_ADDR, 1'($urandom_range(0, 1)), z, op);
                for (int k = 0; k < ms; k++) push(S_MEM_LD, 1'b0, z, op);
                push(S_MEM_LD, 1'b1, z, op);
                push(S_WB_LD, 1'($urandom_range(0, 1)), z, op);
            end
            T_ST: begin
                push(S_MEM_ADDR, 1'($urandom_range(0, 1)), z, op);
                for (int k = 0; k < ms; k++) push(S_MEM_ST, 1'b0, z, op);
                push(S_MEM_ST, 1'b1, z, op);
            end
            T_BR: push(S_BRANCH, 1'($urandom_range(0, 1)), z, op);
            default: for (int k = 0; k < 20; k++) push(S_TRAP, 1'($urandom_range(0, 1)), z, op);
        endcase
    endtask

    // Drive each queued step and compare the DUT against the popped expectation.
    task automatic drain();
        stim_t       s;
        logic [14:0] e;
        while (q_stim.size() > 0) begin
            s = q_stim.pop_front();
            e = q_exp.pop_front();
            opcode = s.op; mem_ready = s.rdy; zero = s.z;
            @(negedge clk);
            n_total++;
            if (act_vec !== e)
                $display("FAIL ctrl st=%0d rdy=%0d: got %b want %b", s.st, s.rdy, act_vec, e);
            else n_pass++;
            n_total++;
            if (instr_retired !== exp_cnt)
                $display("FAIL retired st=%0d: got %0d want %0d", s.st, instr_retired, exp_cnt);
            else n_pass++;
            if (s.st == S_BRANCH) begin
                n_total++;
                if (b_pcw !== s.z)
                    $display("FAIL beq_pcwrite z=%0d: got %b want %b", s.z, b_pcw, s.z);
                else n_pass++;
            end
            if (s.st == S_WB_ALU || s.st == S_WB_LD || s.st == S_BRANCH ||
                (s.st == S_MEM_ST && s.rdy)) exp_cnt = exp_cnt + 32'd1;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_cnt = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b0; opcode = 7'd0;
        @(posedge clk); #1;
        @(negedge clk);
        n_total++;
        if (act_vec !== exp_of(S_FETCH, 1'b0, 1'b0))
            $display("FAIL reset_ctrl: got %b want %b", act_vec, exp_of(S_FETCH, 1'b0, 1'b0));
        else n_pass++;
        n_total++;
        if (instr_retired !== 32'd0 || b_cnt !== 4'd0)
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", instr_retired, b_cnt);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_cnt = 32'd0;
    endtask

    task automatic test_r_type();
        queue_instr(T_R, 0, 0, 1'b0);
        drain();
        queue_instr(T_I, 0, 0, 1'b0);
        drain();
    endtask

    task automatic test_load_stalls();
        queue_instr(T_LD, 2, 3, 1'b0);
        drain();
        queue_instr(T_LD, 0, 0, 1'b1);
        drain();
    endtask

    task automatic test_store();
        queue_instr(T_ST, 0, 0, 1'b0);
        queue_instr(T_ST, 1, 2, 1'b1);
        drain();
    endtask

    task automatic test_branch();
        queue_instr(T_BR, 0, 0, 1'b0);
        drain();
        queue_instr(T_BR, 0, 0, 1'b1);
        drain();
    endtask

    task automatic test_back_to_back();
        queue_instr(T_R, 0, 0, 1'b0);
        queue_instr(T_BR, 1, 0, 1'b1);
        queue_instr(T_LD, 0, 1, 1'b0);
        queue_instr(T_ST, 0, 0, 1'b0);
        queue_instr(T_I, 2, 0, 1'b0);
        drain();
    endtask

    task automatic test_trap();
        queue_instr(T_BAD, 0, 0, 1'b0);
        drain();
        do_reset();
        @(negedge clk);
        n_total++;
        if (illegal !== 1'b0 || MemRead !== 1'b1)
            $display("FAIL trap_clear: got illegal=%b MemRead=%b want 0/1", illegal, MemRead);
        else n_pass++;
        @(posedge clk); #1;
        queue_instr(T_R, 0, 0, 1'b0);
        drain();
    endtask

    task automatic test_reset_mid_store();
        do_reset();
        push(S_FETCH, 1'b1, 1'b0, T_ST);
        push(S_DECODE, 1'b1, 1'b0, T_ST);
        push(S_MEM_ADDR, 1'b1, 1'b0, T_ST);
        push(S_MEM_ST, 1'b0, 1'b0, T_ST);
        drain();
        reset = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if (act_vec !== exp_of(S_FETCH, 1'b0, 1'b0))
            $display("FAIL abort_ctrl: got %b want %b", act_vec, exp_of(S_FETCH, 1'b0, 1'b0));
        else n_pass++;
        n_total++;
        if (instr_retired !== exp_cnt)
            $display("FAIL abort_cnt: got %0d want %0d", instr_retired, exp_cnt);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 17; k++) queue_instr(T_R, 0, 0, 1'b0);
        drain();
        @(negedge clk);
        n_total++;
        if (b_cnt !== 4'd1)
            $display("FAIL wrap4: got %0d want 1", b_cnt);
        else n_pass++;
        n_total++;
        if (instr_retired !== 32'd17)
            $display("FAIL wrap32: got %0d want 17", instr_retired);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_load_stalls();
        test_store();
        test_branch();
        test_back_to_back();
        test_trap();
        test_reset_mid_store();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle sequencer for the RISC-V core. Replaces the single-cycle opcode decoder with a registered state machine. Steps one shared memory port and one shared ALU through fetch, decode, execute, memory and write-back, and stalls on a memory ready handshake. Sits between the instruction register's opcode field and the datapath muxes, register file, PC and memory.

## Interface
Parameters:
- BNE_MODE, 1: branch taken when zero==0 (bne); 0 = taken when zero==1 (beq).
- CNT_W, 32: width of the retired-instruction counter.

Ports (one clock, clk; synchronous active-high reset, reset):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; all state/outputs to reset values on the clock edge where it is high.
- opcode  in  7  instruction[6:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- MemRead, MemWrite  out  1  memory strobes; held until mem_ready.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load instruction register.
- PCWrite  out  1  load PC from the PCSource mux.
- PCSource  out  1  0 = ALU result (PC+4), 1 = ALUOut (branch target).
- ALUSrcA  out  2  00 = PC, 01 = rs1, 10 = old PC.
- ALUSrcB  out  2  00 = rs2, 01 = constant 4, 10 = immediate.
- AluOp  out  2  00 = add, 01 = subtract/compare, 10 = funct-decoded.
- RegWrite  out  1  register-file write enable.
- MemToReg  out  1  write-back source: 0 = ALUOut, 1 = MDR.
- illegal  out  1  sticky unknown-opcode flag.
- instr_retired  out  CNT_W  count of completed instructions.

## Operation
- States (shared package enum): FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_LD, MEM_ST, WB_ALU, WB_LD, BRANCH, TRAP.
- Outputs not listed for a state are 0. AluOp, ALUSrcA and ALUSrcB default to 00.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcB=01.
  - On mem_ready: IRWrite=1, PCWrite=1, PCSource=0, go to DECODE. Otherwise stay.
- DECODE: ALUSrcA=10, ALUSrcB=10 (branch target into ALUOut). Next state by opcode:
  - 0110011 goes to EXEC_R.
  - 0010011 goes to EXEC_I.
  - 0000011 and 0100011 go to MEM_ADDR.
  - 1100011 goes to BRANCH.
  - Anything else goes to TRAP.
- EXEC_R: ALUSrcA=01, ALUSrcB=00, AluOp=10, then WB_ALU.
- EXEC_I: ALUSrcA=01, ALUSrcB=10, AluOp=10, then WB_ALU.
- MEM_ADDR: ALUSrcA=01, ALUSrcB=10, AluOp=00. Goes to MEM_LD for a load, MEM_ST for a store.
- MEM_LD: MemRead=1, IorD=1; on mem_ready go to WB_LD.
- MEM_ST: MemWrite=1, IorD=1; on mem_ready retire and go to FETCH.
- WB_ALU: RegWrite=1, MemToReg=0; retire, go to FETCH.
- WB_LD: RegWrite=1, MemToReg=1; retire, go to FETCH.
- BRANCH:
  - Outputs: ALUSrcA=01, ALUSrcB=00, AluOp=01, PCSource=1.
  - PCWrite = (zero ^ BNE_MODE). Evaluated combinationally in this cycle only.
  - Retire, go to FETCH.
- TRAP: illegal=1; stay until reset. No memory strobes, no writes, no counter change.
- Retire: instr_retired increments by 1 on the edge leaving a retiring state. It wraps modulo 2^CNT_W.
- The opcode is sampled only in DECODE and MEM_ADDR.

## Timing
- State register updates on the rising edge of clk.
- Outputs are decoded combinationally from the state. PCWrite and IRWrite also depend combinationally on mem_ready (FETCH) and zero (BRANCH).
- Reset values: state=FETCH, illegal=0, instr_retired=0. All strobes follow FETCH decode: MemRead=1, all other write enables 0.
- Cycle counts with zero-wait memory (mem_ready high in the first cycle):
  - R-type and I-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Each cycle with mem_ready low in FETCH, MEM_LD or MEM_ST adds exactly one cycle. Strobes, IorD and the address mux stay stable throughout.
- mem_ready is ignored in all other states.
- Reset asserted in any state, including mid-access, returns to FETCH on that edge. The aborted instruction does not retire.
- The counter increment and the FETCH entry happen on the same edge. There is no bubble between instructions.

## Structure
- Shared package holds:
  - the state enum;
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH);
  - AluOp, ALUSrcA and ALUSrcB encodings.
- Sub-module: retire_counter (CNT_W-bit synchronous counter with enable, synchronous reset). The FSM stays in this module.

## Test plan
- Reset with mem_ready=1, then opcode 0110011:
  - states run FETCH → DECODE → EXEC_R → WB_ALU → FETCH;
  - RegWrite=1 only in cycle 4;
  - instr_retired=1.
- Load (0000011), mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_LD:
  - completes in 10 cycles;
  - MemRead and IorD stable during the stalls;
  - MemToReg=1 with RegWrite in WB_LD.
- Branch 1100011 with BNE_MODE=1:
  - zero=0 → PCWrite=1, PCSource=1 in BRANCH;
  - zero=1 → PCWrite=0;
  - both cases retire after 3 cycles.
- Opcode 1111111:
  - enters TRAP after DECODE;
  - illegal=1 is held for 20 cycles with no MemWrite or RegWrite;
  - reset clears illegal, and the next FETCH proceeds.
- Reset asserted during MEM_ST with mem_ready low:
  - next state is FETCH, MemWrite=0;
  - instr_retired unchanged.
- CNT_W=4, run 17 R-type instructions: instr_retired wraps to 1.
